// File: rtl/pipeline_result_collector.sv
// Fast-clock collector for the slow_clk pipeline: detects qualified slow_clk rises,
// drops the first FILL_SKIP of them, then queues s2_result in a FWFT FIFO for the consumer.
module pipeline_result_collector #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int FILL_SKIP = 2
) (
    input  logic                       fast_clk,
    input  logic                       rst_n,
    input  logic                       slow_clk,
    input  logic [DATA_W-1:0]          s2_result,
    input  logic                       enable,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       clr_ovf,
    output logic [15:0]                capture_count
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W  = $clog2(DEPTH) + 1;
    localparam int SKIP_W = (FILL_SKIP > 0) ? $clog2(FILL_SKIP + 1) : 1;

    localparam logic [SKIP_W-1:0] SKIP_MAX  = SKIP_W'(FILL_SKIP);
    localparam logic [SKIP_W-1:0] SKIP_ONE  = SKIP_W'(1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
    localparam logic [LVL_W-1:0]  LVL_ZERO  = '0;
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

    // Reset asserts asynchronously but is released only on a fast_clk edge.
    logic r_rst_meta;
    logic r_rst_sync;
    logic w_rst_n;

    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_rst_n = r_rst_sync;

    logic                r_slow_q;
    logic [SKIP_W-1:0]   r_skip_cnt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [LVL_W-1:0]    r_level;
    logic                r_overflow;
    logic [15:0]         r_capture_count;

    logic w_rise;
    logic w_qual;
    logic w_skipping;
    logic w_push;
    logic w_full;
    logic w_pop;
    logic w_wr;
    logic w_drop;

    assign w_rise     = slow_clk & ~r_slow_q;
    assign w_qual     = w_rise & enable;
    assign w_skipping = (r_skip_cnt < SKIP_MAX);
    assign w_push     = w_qual & ~w_skipping;
    assign w_full     = (r_level == LVL_FULL);
    assign w_pop      = (r_level != LVL_ZERO) & out_ready;
    // When full, a same-cycle pop frees the head slot, which is also the write slot.
    assign w_wr       = w_push & (~w_full | w_pop);
    assign w_drop     = w_push & w_full & ~w_pop;

    always_ff @(posedge fast_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_slow_q   <= 1'b1;
            r_skip_cnt <= '0;
        end else begin
            r_slow_q <= slow_clk;
            if (w_qual && w_skipping) begin
                r_skip_cnt <= r_skip_cnt + SKIP_ONE;
            end
        end
    end

    always_ff @(posedge fast_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= s2_result;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge fast_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_overflow      <= 1'b0;
            r_capture_count <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
            if (w_wr) begin
                r_capture_count <= r_capture_count + 16'd1;
            end
        end
    end

    assign out_valid     = (r_level != LVL_ZERO);
    assign out_data      = r_mem[r_rd_ptr];
    assign level         = r_level;
    assign overflow      = r_overflow;
    assign capture_count = r_capture_count;

endmodule

// File: tb/tb_pipeline_result_collector.sv
// Directed bench for pipeline_result_collector: table of slow_clk edges plus
// hand-written sequences for full/overflow/enable/reset corner cases.
module tb_pipeline_result_collector;

    logic        fast_clk;
    logic        rst_n;
    logic        slow_clk;
    logic [7:0]  s2_result;
    logic        enable;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [2:0]  level;
    logic        overflow;
    logic        clr_ovf;
    logic [15:0] capture_count;

    int n_total = 0;
    int n_bad   = 0;

    pipeline_result_collector #(
        .DATA_W   (8),
        .DEPTH    (4),
        .FILL_SKIP(2)
    ) dut (
        .fast_clk     (fast_clk),
        .rst_n        (rst_n),
        .slow_clk     (slow_clk),
        .s2_result    (s2_result),
        .enable       (enable),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .level        (level),
        .overflow     (overflow),
        .clr_ovf      (clr_ovf),
        .capture_count(capture_count)
    );

    initial begin
        fast_clk = 1'b0;
        forever #5 fast_clk = ~fast_clk;
    end

    typedef struct packed {
        logic        en;
        logic        rdy;
        logic [7:0]  d;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic [2:0]  exp_level;
        logic        exp_ovf;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge fast_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic v, input logic [7:0] d,
                             input logic [2:0] lvl, input logic ovf, input logic [15:0] cnt);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".level"}, 32'(level), 32'(lvl));
        chk({tag, ".ovf"}, 32'(overflow), 32'(ovf));
        chk({tag, ".cnt"}, 32'(capture_count), 32'(cnt));
        if (v) chk({tag, ".data"}, 32'(out_data), 32'(d));
    endtask

    task automatic rise(input logic [7:0] d);
        s2_result = d;
        slow_clk  = 1'b1;
        tick();
    endtask

    task automatic tail();
        repeat (3) tick();
        slow_clk = 1'b0;
        repeat (4) tick();
    endtask

    task automatic do_reset(input logic slow_lvl);
        rst_n    = 1'b0;
        slow_clk = slow_lvl;
        #1;
        chk_state("rst_async", 1'b0, 8'd0, 3'd0, 1'b0, 16'd0);
        chk("rst_async.data", 32'(out_data), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk_state("rst_rel", 1'b0, 8'd0, 3'd0, 1'b0, 16'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        slow_clk  = 1'b0;
        s2_result = 8'd0;
        enable    = 1'b1;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;

        //            en    rdy   d      v     data   lvl   ovf   cnt
        vecs[0] = '{1'b1, 1'b1, 8'd10, 1'b0, 8'd0,  3'd0, 1'b0, 16'd0};
        vecs[1] = '{1'b1, 1'b1, 8'd11, 1'b0, 8'd0,  3'd0, 1'b0, 16'd0};
        vecs[2] = '{1'b1, 1'b1, 8'd12, 1'b1, 8'd12, 3'd1, 1'b0, 16'd1};
        vecs[3] = '{1'b1, 1'b1, 8'd13, 1'b1, 8'd13, 3'd1, 1'b0, 16'd2};
        vecs[4] = '{1'b1, 1'b1, 8'd14, 1'b1, 8'd14, 3'd1, 1'b0, 16'd3};
        vecs[5] = '{1'b1, 1'b0, 8'd20, 1'b1, 8'd20, 3'd1, 1'b0, 16'd4};
        vecs[6] = '{1'b1, 1'b0, 8'd21, 1'b1, 8'd20, 3'd2, 1'b0, 16'd5};
        vecs[7] = '{1'b1, 1'b0, 8'd22, 1'b1, 8'd20, 3'd3, 1'b0, 16'd6};
        vecs[8] = '{1'b1, 1'b0, 8'd23, 1'b1, 8'd20, 3'd4, 1'b0, 16'd7};
        vecs[9] = '{1'b1, 1'b0, 8'd24, 1'b1, 8'd20, 3'd4, 1'b1, 16'd7};

        do_reset(1'b0);

        // Skip, stream with ready=1, then fill past full with ready=0.
        for (int i = 0; i < 10; i++) begin
            enable    = vecs[i].en;
            out_ready = vecs[i].rdy;
            rise(vecs[i].d);
            chk_state($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                      vecs[i].exp_level, vecs[i].exp_ovf, vecs[i].exp_cnt);
            tail();
            if (vecs[i].rdy) chk($sformatf("vec%0d.drained", i), 32'(level), 32'd0);
        end

        chk("hold.data", 32'(out_data), 32'd20);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain2.%0d", i), 32'(out_data), 32'(20 + i));
            tick();
        end
        out_ready = 1'b0;
        chk_state("drain2.end", 1'b0, 8'd0, 3'd0, 1'b1, 16'd7);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr2.ovf", 32'(overflow), 32'd0);

        // Push and pop on the same edge while full.
        for (int i = 0; i < 4; i++) begin
            rise(8'(30 + i));
            tail();
        end
        chk_state("full3", 1'b1, 8'd30, 3'd4, 1'b0, 16'd11);
        out_ready = 1'b1;
        rise(8'd34);
        out_ready = 1'b0;
        chk_state("pushpop3", 1'b1, 8'd31, 3'd4, 1'b0, 16'd12);
        tail();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain3.%0d", i), 32'(out_data), 32'(31 + i));
            tick();
        end
        out_ready = 1'b0;
        chk("drain3.level", 32'(level), 32'd0);

        // enable=0 freezes skip; pushes start on the third enabled edge.
        do_reset(1'b0);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rise(8'(40 + i));
            tail();
        end
        chk_state("dis4", 1'b0, 8'd0, 3'd0, 1'b0, 16'd0);
        enable = 1'b1;
        rise(8'd43);
        tail();
        rise(8'd44);
        tail();
        chk("en4.skip_level", 32'(level), 32'd0);
        rise(8'd45);
        chk_state("en4.push", 1'b1, 8'd45, 3'd1, 1'b0, 16'd1);
        tail();

        // Drop and clear on the same edge: set wins.
        for (int i = 0; i < 3; i++) begin
            rise(8'(46 + i));
            tail();
        end
        chk_state("full5", 1'b1, 8'd45, 3'd4, 1'b0, 16'd4);
        clr_ovf = 1'b1;
        rise(8'd49);
        clr_ovf = 1'b0;
        chk_state("dropclr5", 1'b1, 8'd45, 3'd4, 1'b1, 16'd4);
        tail();
        chk("ovf5.sticky", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr5.ovf", 32'(overflow), 32'd0);

        // Reset mid-stream with slow_clk high at release.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_state("pre6", 1'b1, 8'd46, 3'd3, 1'b0, 16'd4);
        do_reset(1'b1);
        repeat (4) tick();
        chk("rst6.no_edge", 32'(level), 32'd0);
        slow_clk = 1'b0;
        repeat (4) tick();
        rise(8'd50);
        tail();
        rise(8'd51);
        tail();
        chk_state("rst6.skip", 1'b0, 8'd0, 3'd0, 1'b0, 16'd0);
        rise(8'd52);
        chk_state("rst6.push", 1'b1, 8'd52, 3'd1, 1'b0, 16'd1);
        tail();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
